uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx serializer among NUM_REQ byte producers, e.g. the RX echo path, a status/response generator and a debug dumper.
- Sits between the producers and uart_tx. It owns tx_start and tx_data and watches tx_busy.
- Uses round-robin arbitration with message locking, so that multi-byte messages are never interleaved on the serial line.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- BUSY_WAIT_MAX, 4, cycles to wait after tx_start for tx_busy to rise before the byte is declared lost.
- LOCK_TIMEOUT, 50000, idle cycles a lock owner may go without presenting valid before the lock is forcibly released (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of its message
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- tx_data  out  8  byte to uart_tx
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_busy  in  1  uart_tx busy
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester
- locked  out  1  a message is in progress
- lock_abort  out  1  one-cycle pulse when a lock times out
- busy_err  out  1  one-cycle pulse when tx_busy fails to rise within BUSY_WAIT_MAX
- tx_count  out  16  bytes issued; wraps at 65535 -> 0
- debug_state  out  2  FSM state encoding, for Signal Tap

Behaviour:
- Reset: state IDLE. All of the following are 0: req_ready, tx_start, tx_data, grant_id, locked, lock_abort, busy_err, tx_count. The round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority.
- Handshake: a byte transfers on the cycle req_ready[i]=1. The requester holds valid, data and last stable until that cycle, and may drop valid the following cycle. At most one req_ready bit is high per cycle.
- FSM states and encodings: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3.
- IDLE:
  - When unlocked, tx_busy=0 and any req_valid is high: select the first requester with valid set, searching from pointer+1 upward and wrapping modulo NUM_REQ.
  - When locked: only the owner (grant_id) is eligible.
  - On selection: pulse req_ready[winner], latch req_data into tx_data, set grant_id, set locked=~req_last[winner], then go to ISSUE.
  - When req_last=1: pointer <= winner. The pointer does not move on non-last bytes.
- ISSUE: tx_start=1 for exactly one cycle; tx_count increments; go to WAIT_BUSY. tx_data holds until the next grant.
- WAIT_BUSY:
  - On tx_busy=1: go to WAIT_DONE.
  - After BUSY_WAIT_MAX cycles with tx_busy=0: pulse busy_err and return to IDLE. The lock state is unchanged and the byte is not retried.
- WAIT_DONE: when tx_busy=0, go to IDLE.
- Latency: grant -> tx_start is 1 cycle. The earliest next grant is the cycle after tx_busy falls.
- Lock timeout:
  - A counter runs only while locked=1 in IDLE with req_valid[owner]=0. It clears on any grant.
  - On reaching LOCK_TIMEOUT: locked <= 0, lock_abort pulses, pointer <= owner, and normal arbitration resumes the next cycle.
- Simultaneous events:
  - If the timeout and the owner's valid occur in the same cycle, the grant wins and there is no abort.
  - A requester raising valid while another is in WAIT_DONE waits; there is no preemption.
- Requests are ignored while tx_busy=1 in IDLE, e.g. when uart_tx was started externally.
- Reset mid-operation returns everything to reset values immediately. A byte already started inside uart_tx is uart_tx's concern. Requesters must treat an unacknowledged byte as not sent.

Decomposition:
- Shared package uart_ctrl_pkg holds:
  - the FSM state constants (ARB_IDLE, ARB_ISSUE, ARB_WAIT_BUSY, ARB_WAIT_DONE);
  - the CLK_HZ = 50_000_000 constant;
  - a clog2 function.
- One natural sub-module, rr_pick: purely combinational. Inputs are the request mask and pointer; outputs are the winner index and an any-request flag. It is reused by future arbiters.
- All other logic stays in uart_tx_arbiter.

Test Plan:
- Single requester:
  - Stimulus: NUM_REQ=2; req0 sends 0x41 with last=1; tx_busy rises 1 cycle after tx_start and holds 10 cycles.
  - Response: req_ready[0] one pulse, tx_start 1 cycle later with tx_data=0x41, tx_count=1, locked stays 0.
- Round-robin:
  - Stimulus: req0 and req1 both valid continuously with last=1; req0 sends 0x10, req1 sends 0x20.
  - Response: issue order 0x10, 0x20, 0x10, 0x20; grant_id alternates 0,1,0,1.
- Message lock:
  - Stimulus: req1 sends "OK\n" (0x4F, 0x4B, 0x0A, last only on 0x0A) while req0 is valid throughout.
  - Response: all three req1 bytes issue contiguously, locked=1 until 0x0A is accepted, then req0 is granted.
- Lock timeout:
  - Stimulus: LOCK_TIMEOUT=20; req0 sends 0x55 with last=0, then drops valid; req1 valid.
  - Response: lock_abort pulses 20 idle cycles after the grant; req1 is granted the next eligible cycle.
- Busy timeout:
  - Stimulus: tx_busy held 0 after tx_start.
  - Response: busy_err pulses after 4 cycles; FSM returns to IDLE; next request is served.
- Reset mid-transfer:
  - Stimulus: assert rst_n=0 in WAIT_DONE.
  - Response: all outputs 0 and debug_state=0 immediately; the first grant after release goes to req0.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control blocks: arbiter FSM encodings,
// system clock rate and a constant-friendly clog2.
package uart_ctrl_pkg;

   localparam int CLK_HZ = 50_000_000;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_ISSUE     = 2'd1,
      ARB_WAIT_BUSY = 2'd2,
      ARB_WAIT_DONE = 2'd3
   } arb_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req strictly after ptr,
// wrapping modulo N.
module rr_pick
   import uart_ctrl_pkg::*;
#(
   parameter  int N = 2,
   localparam int W = clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] win,
   output logic         any
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W:0]     sh;
   logic [W-1:0]   off;
   logic [W+1:0]   sum;

   always_comb begin
      dbl = {req, req};
      sh  = {1'b0, ptr} + 1'b1;
      // dbl repeats with period N, so a shift by N is the same as no shift
      rot = N'(dbl >> sh);
      off = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = W'(i);
            any = 1'b1;
         end
      end
      sum = (W + 2)'(sh) + (W + 2)'(off);
      if (sum >= (W + 2)'(N)) sum = sum - (W + 2)'(N);
      win = sum[W-1:0];
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers, with
// message locking so multi-byte messages are never interleaved.
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter  int NUM_REQ       = 2,
   parameter  int BUSY_WAIT_MAX = 4,
   parameter  int LOCK_TIMEOUT  = 50000,
   localparam int GW            = clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0][7:0] req_data,
   input  logic [NUM_REQ-1:0]      req_last,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [7:0]              tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic [GW-1:0]           grant_id,
   output logic                    locked,
   output logic                    lock_abort,
   output logic                    busy_err,
   output logic [15:0]             tx_count,
   output logic [1:0]              debug_state
);

   localparam int BW = clog2(BUSY_WAIT_MAX + 1);
   localparam int LW = clog2(LOCK_TIMEOUT + 1);

   arb_state_e         state;
   logic [GW-1:0]      ptr;
   logic [GW-1:0]      win;
   logic               any;
   logic [NUM_REQ-1:0] owner_mask;
   logic [NUM_REQ-1:0] elig;
   logic [BW-1:0]      busy_cnt;
   logic [LW-1:0]      lock_cnt;

   // while a message is open only its owner may compete
   always_comb begin
      owner_mask           = '0;
      owner_mask[grant_id] = 1'b1;
      elig                 = locked ? (req_valid & owner_mask) : req_valid;
   end

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req (elig),
      .ptr (ptr),
      .win (win),
      .any (any)
   );

   assign debug_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         ptr        <= GW'(NUM_REQ - 1);
         req_ready  <= '0;
         tx_data    <= '0;
         tx_start   <= 1'b0;
         grant_id   <= '0;
         locked     <= 1'b0;
         lock_abort <= 1'b0;
         busy_err   <= 1'b0;
         tx_count   <= '0;
         busy_cnt   <= '0;
         lock_cnt   <= '0;
      end else begin
         req_ready  <= '0;
         tx_start   <= 1'b0;
         lock_abort <= 1'b0;
         busy_err   <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (!tx_busy && any) begin
                  req_ready[win] <= 1'b1;
                  tx_data        <= req_data[win];
                  grant_id       <= win;
                  locked         <= ~req_last[win];
                  if (req_last[win]) ptr <= win;
                  lock_cnt       <= '0;
                  state          <= ARB_ISSUE;
               end else if (locked && !req_valid[grant_id]) begin
                  // owner went quiet mid-message: reclaim the line eventually
                  if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
                     locked     <= 1'b0;
                     lock_abort <= 1'b1;
                     ptr        <= grant_id;
                     lock_cnt   <= '0;
                  end else begin
                     lock_cnt <= lock_cnt + 1'b1;
                  end
               end
            end
            ARB_ISSUE: begin
               tx_start <= 1'b1;
               tx_count <= tx_count + 1'b1;
               busy_cnt <= '0;
               state    <= ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= ARB_WAIT_DONE;
               end else if (busy_cnt == BW'(BUSY_WAIT_MAX - 1)) begin
                  busy_err <= 1'b1;
                  state    <= ARB_IDLE;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
            end
            ARB_WAIT_DONE: begin
               if (!tx_busy) state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx busy model and
// per-requester byte queues.
module tb_uart_tx_arbiter;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid, req_last, req_ready;
   logic [1:0][7:0] req_data;
   logic [7:0]      tx_data;
   logic            tx_start, tx_busy;
   logic [0:0]      grant_id;
   logic            locked, lock_abort, busy_err;
   logic [15:0]     tx_count;
   logic [1:0]      debug_state;

   int checks = 0, passed = 0, cyc = 0;
   bit busy_en = 1'b1;
   int bcnt;

   logic [8:0] q0[$], q1[$];
   logic [7:0] iss_data[$];
   logic       iss_gid[$], iss_lock[$], rdy_gid[$], ab_locked[$];
   int         iss_cyc[$], rdy_cyc[$], ab_cyc[$], be_cyc[$], idle_cyc[$];
   logic [1:0] be_state[$];
   logic [1:0] prev_st;
   bit         rdy_multi, lock_seen;

   uart_tx_arbiter #(.NUM_REQ(2), .BUSY_WAIT_MAX(4), .LOCK_TIMEOUT(20)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
      .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
      .locked(locked), .lock_abort(lock_abort), .busy_err(busy_err),
      .tx_count(tx_count), .debug_state(debug_state)
   );

   always #10 clk = ~clk;

   // uart_tx stand-in: busy for 10 cycles starting the cycle after tx_start
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bcnt <= 0;
      else if (tx_start && busy_en) bcnt <= 10;
      else if (bcnt != 0) bcnt <= bcnt - 1;
   end
   assign tx_busy = (bcnt != 0);

   task automatic drive();
      req_valid   = {q1.size() != 0, q0.size() != 0};
      req_data[0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
      req_last[0] = (q0.size() != 0) ? q0[0][8] : 1'b0;
      req_data[1] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
      req_last[1] = (q1.size() != 0) ? q1[0][8] : 1'b0;
   endtask

   task automatic clear_logs();
      iss_data.delete(); iss_gid.delete(); iss_lock.delete(); iss_cyc.delete();
      rdy_gid.delete(); rdy_cyc.delete(); ab_cyc.delete(); ab_locked.delete();
      be_cyc.delete(); be_state.delete(); idle_cyc.delete();
      rdy_multi = 1'b0; lock_seen = 1'b0; prev_st = debug_state;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (req_ready != 2'b00) begin
         rdy_gid.push_back(req_ready[1]);
         rdy_cyc.push_back(cyc);
         if (req_ready == 2'b11) rdy_multi = 1'b1;
      end
      if (req_ready[0] && q0.size() != 0) void'(q0.pop_front());
      if (req_ready[1] && q1.size() != 0) void'(q1.pop_front());
      if (tx_start) begin
         iss_data.push_back(tx_data); iss_gid.push_back(grant_id[0]);
         iss_lock.push_back(locked);  iss_cyc.push_back(cyc);
      end
      if (lock_abort) begin ab_cyc.push_back(cyc); ab_locked.push_back(locked); end
      if (busy_err) begin be_cyc.push_back(cyc); be_state.push_back(debug_state); end
      if (debug_state == 2'd0 && prev_st != 2'd0) idle_cyc.push_back(cyc);
      if (locked) lock_seen = 1'b1;
      prev_st = debug_state;
      drive();
   endtask

   task automatic drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (q0.size() == 0 && q1.size() == 0 && debug_state == 2'd0 && !tx_busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q0.delete(); q1.delete();
      busy_en = 1'b1;
      drive();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready); else passed++;
      checks++; if (tx_start !== 1'b0) $display("FAIL reset_start: got %b want 0", tx_start); else passed++;
      checks++; if (tx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", tx_data); else passed++;
      checks++; if (grant_id !== 1'b0) $display("FAIL reset_gid: got %b want 0", grant_id); else passed++;
      checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passed++;
      checks++; if (lock_abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", lock_abort); else passed++;
      checks++; if (busy_err !== 1'b0) $display("FAIL reset_busyerr: got %b want 0", busy_err); else passed++;
      checks++; if (tx_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", tx_count); else passed++;
      checks++; if (debug_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", debug_state); else passed++;
   endtask

   task automatic test_single();
      bit ok;
      do_reset();
      q0.push_back({1'b1, 8'h41});
      drive();
      drain(60, ok);
      checks++; if (ok !== 1'b1) $display("FAIL single_done: got %b want 1", ok); else passed++;
      checks++; if (rdy_gid.size() !== 1) $display("FAIL single_readys: got %0d want 1", rdy_gid.size()); else passed++;
      checks++; if (iss_data.size() !== 1) $display("FAIL single_issues: got %0d want 1", iss_data.size()); else passed++;
      if (rdy_gid.size() == 1 && iss_data.size() == 1) begin
         checks++; if (rdy_gid[0] !== 1'b0) $display("FAIL single_gid: got %b want 0", rdy_gid[0]); else passed++;
         checks++; if (iss_data[0] !== 8'h41) $display("FAIL single_data: got %h want 41", iss_data[0]); else passed++;
         checks++; if (iss_cyc[0] - rdy_cyc[0] !== 1) $display("FAIL single_latency: got %0d want 1", iss_cyc[0] - rdy_cyc[0]); else passed++;
      end
      checks++; if (tx_count !== 16'd1) $display("FAIL single_count: got %0d want 1", tx_count); else passed++;
      checks++; if (lock_seen !== 1'b0) $display("FAIL single_locked: got %b want 0", lock_seen); else passed++;
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [7:0] ed[4];
      logic       eg[4];
      ed = '{8'h10, 8'h20, 8'h10, 8'h20};
      eg = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      repeat (2) begin q0.push_back({1'b1, 8'h10}); q1.push_back({1'b1, 8'h20}); end
      drive();
      drain(200, ok);
      checks++; if (ok !== 1'b1) $display("FAIL rr_done: got %b want 1", ok); else passed++;
      checks++; if (iss_data.size() !== 4) $display("FAIL rr_issues: got %0d want 4", iss_data.size()); else passed++;
      if (iss_data.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++; if (iss_data[k] !== ed[k]) $display("FAIL rr_data%0d: got %h want %h", k, iss_data[k], ed[k]); else passed++;
            checks++; if (iss_gid[k] !== eg[k]) $display("FAIL rr_gid%0d: got %b want %b", k, iss_gid[k], eg[k]); else passed++;
         end
      end
      checks++; if (rdy_multi !== 1'b0) $display("FAIL rr_onehot: got %b want 0", rdy_multi); else passed++;
      checks++; if (tx_count !== 16'd4) $display("FAIL rr_count: got %0d want 4", tx_count); else passed++;
   endtask

   task automatic test_message_lock();
      bit ok;
      logic [7:0] ed[5];
      logic       eg[5], el[5];
      ed = '{8'h4F, 8'h4B, 8'h0A, 8'h30, 8'h30};
      eg = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      el = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      q1.push_back({1'b0, 8'h4F}); q1.push_back({1'b0, 8'h4B}); q1.push_back({1'b1, 8'h0A});
      drive();
      for (int i = 0; i < 10 && rdy_cyc.size() == 0; i++) step();
      repeat (2) q0.push_back({1'b1, 8'h30});
      drive();
      drain(300, ok);
      checks++; if (ok !== 1'b1) $display("FAIL lock_done: got %b want 1", ok); else passed++;
      checks++; if (iss_data.size() !== 5) $display("FAIL lock_issues: got %0d want 5", iss_data.size()); else passed++;
      if (iss_data.size() == 5) begin
         for (int k = 0; k < 5; k++) begin
            checks++; if (iss_data[k] !== ed[k]) $display("FAIL lock_data%0d: got %h want %h", k, iss_data[k], ed[k]); else passed++;
            checks++; if (iss_gid[k] !== eg[k]) $display("FAIL lock_gid%0d: got %b want %b", k, iss_gid[k], eg[k]); else passed++;
            checks++; if (iss_lock[k] !== el[k]) $display("FAIL lock_flag%0d: got %b want %b", k, iss_lock[k], el[k]); else passed++;
         end
      end
   endtask

   task automatic test_lock_timeout();
      bit ok;
      do_reset();
      q0.push_back({1'b0, 8'h55});
      q1.push_back({1'b1, 8'h66});
      drive();
      for (int i = 0; i < 200 && iss_data.size() < 2; i++) step();
      checks++; if (iss_data.size() !== 2) $display("FAIL lto_issues: got %0d want 2", iss_data.size()); else passed++;
      checks++; if (ab_cyc.size() !== 1) $display("FAIL lto_aborts: got %0d want 1", ab_cyc.size()); else passed++;
      if (iss_data.size() == 2 && ab_cyc.size() == 1 && idle_cyc.size() >= 1 && rdy_cyc.size() == 2) begin
         checks++; if (iss_data[0] !== 8'h55) $display("FAIL lto_data0: got %h want 55", iss_data[0]); else passed++;
         checks++; if (iss_lock[0] !== 1'b1) $display("FAIL lto_lock0: got %b want 1", iss_lock[0]); else passed++;
         checks++; if (ab_cyc[0] - idle_cyc[0] !== 20) $display("FAIL lto_delay: got %0d want 20", ab_cyc[0] - idle_cyc[0]); else passed++;
         checks++; if (ab_locked[0] !== 1'b0) $display("FAIL lto_unlock: got %b want 0", ab_locked[0]); else passed++;
         checks++; if (rdy_cyc[1] - ab_cyc[0] !== 1) $display("FAIL lto_regrant: got %0d want 1", rdy_cyc[1] - ab_cyc[0]); else passed++;
         checks++; if (rdy_gid[1] !== 1'b1) $display("FAIL lto_gid1: got %b want 1", rdy_gid[1]); else passed++;
         checks++; if (iss_data[1] !== 8'h66) $display("FAIL lto_data1: got %h want 66", iss_data[1]); else passed++;
      end
      drain(100, ok);
      checks++; if (ok !== 1'b1) $display("FAIL lto_done: got %b want 1", ok); else passed++;
   endtask

   task automatic test_busy_timeout();
      bit ok;
      do_reset();
      busy_en = 1'b0;
      q0.push_back({1'b1, 8'h77});
      drive();
      for (int i = 0; i < 50 && be_cyc.size() == 0; i++) step();
      checks++; if (be_cyc.size() !== 1) $display("FAIL bto_errs: got %0d want 1", be_cyc.size()); else passed++;
      if (be_cyc.size() == 1 && iss_cyc.size() == 1) begin
         checks++; if (be_cyc[0] - iss_cyc[0] !== 4) $display("FAIL bto_delay: got %0d want 4", be_cyc[0] - iss_cyc[0]); else passed++;
         checks++; if (be_state[0] !== 2'd0) $display("FAIL bto_state: got %0d want 0", be_state[0]); else passed++;
      end
      busy_en = 1'b1;
      q1.push_back({1'b1, 8'h88});
      drive();
      drain(100, ok);
      checks++; if (ok !== 1'b1) $display("FAIL bto_done: got %b want 1", ok); else passed++;
      checks++; if (iss_data.size() !== 2) $display("FAIL bto_issues: got %0d want 2", iss_data.size()); else passed++;
      if (iss_data.size() == 2) begin
         checks++; if (iss_data[1] !== 8'h88) $display("FAIL bto_data1: got %h want 88", iss_data[1]); else passed++;
         checks++; if (iss_gid[1] !== 1'b1) $display("FAIL bto_gid1: got %b want 1", iss_gid[1]); else passed++;
      end
      checks++; if (tx_count !== 16'd2) $display("FAIL bto_count: got %0d want 2", tx_count); else passed++;
      checks++; if (be_cyc.size() !== 1) $display("FAIL bto_errs_final: got %0d want 1", be_cyc.size()); else passed++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      q0.push_back({1'b1, 8'h99});
      drive();
      for (int i = 0; i < 20 && debug_state != 2'd3; i++) step();
      checks++; if (debug_state !== 2'd3) $display("FAIL rmid_reach: got %0d want 3", debug_state); else passed++;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (debug_state !== 2'd0) $display("FAIL rmid_state: got %0d want 0", debug_state); else passed++;
      checks++; if (tx_count !== 16'd0) $display("FAIL rmid_count: got %0d want 0", tx_count); else passed++;
      checks++; if (tx_data !== 8'h00) $display("FAIL rmid_data: got %h want 00", tx_data); else passed++;
      checks++; if ({req_ready, tx_start, grant_id, locked, lock_abort, busy_err} !== 7'd0)
         $display("FAIL rmid_flags: got %b want 0000000", {req_ready, tx_start, grant_id, locked, lock_abort, busy_err}); else passed++;
      q0.delete(); q1.delete();
      q1.push_back({1'b1, 8'hAA});
      q0.push_back({1'b1, 8'hBB});
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      drain(100, ok);
      checks++; if (ok !== 1'b1) $display("FAIL rmid_done: got %b want 1", ok); else passed++;
      checks++; if (iss_data.size() !== 2) $display("FAIL rmid_issues: got %0d want 2", iss_data.size()); else passed++;
      if (iss_data.size() == 2) begin
         checks++; if (iss_gid[0] !== 1'b0) $display("FAIL rmid_gid0: got %b want 0", iss_gid[0]); else passed++;
         checks++; if (iss_data[0] !== 8'hBB) $display("FAIL rmid_data0: got %h want bb", iss_data[0]); else passed++;
         checks++; if (iss_data[1] !== 8'hAA) $display("FAIL rmid_data1: got %h want aa", iss_data[1]); else passed++;
      end
   endtask

   initial begin
      q0.delete(); q1.delete();
      drive();
      test_reset();
      test_single();
      test_round_robin();
      test_message_lock();
      test_lock_timeout();
      test_busy_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
